// File: rtl/accum_pkg.sv
// Shared types and helpers for the accumulation sequencer.
// Holds the FSM state encoding and the saturation limit functions.
package accum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        CHECK,
        DONE
    } state_t;

    // Limits are returned 64 bits wide; callers keep the low n bits.
    function automatic logic [63:0] sat_max(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int n);
        return 64'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/accum_sequencer.sv
// Drives a sibling registered adder to accumulate LEN signed operands with
// saturation, then offers the final sum on a valid/ready output.
module accum_sequencer
    import accum_pkg::*;
#(
    parameter int N = 32,
    parameter int LEN = 8,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_refresh,
    input  logic [N-1:0] add_result,
    input  logic         add_overflow,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_sat
);

    localparam logic [63:0] MAX_W64 = sat_max(N);
    localparam logic [63:0] MIN_W64 = sat_min(N);
    localparam logic [N-1:0] SAT_MAX = MAX_W64[N-1:0];
    localparam logic [N-1:0] SAT_MIN = MIN_W64[N-1:0];
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_t state, state_next;
    logic [N-1:0] acc;
    logic [N-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic sat;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (in_valid) state_next = ADD;
            ADD:     state_next = CHECK;
            CHECK:   state_next = (cnt == LAST) ? DONE : LOAD;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Adder inputs stay on acc/opnd through CHECK, so its registered result is still valid there.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
            sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                        sat <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_valid) opnd <= in_data;
                end
                CHECK: begin
                    if (add_overflow) begin
                        acc <= acc[N-1] ? SAT_MIN : SAT_MAX;
                        sat <= 1'b1;
                    end else begin
                        acc <= add_result;
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign in_ready    = (state == LOAD);
    assign add_refresh = (state == ADD);
    assign out_valid   = (state == DONE);
    assign add_a       = acc;
    assign add_b       = opnd;
    assign out_data    = acc;
    assign out_sat     = sat;

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer (N=8, LEN=4) with a behavioural
// stand-in for the sibling registered adder.
module tb_accum_sequencer;

    localparam int N = 8;
    localparam int LEN = 4;

    logic clk = 1'b0;
    logic rst, start, busy;
    logic in_valid, in_ready;
    logic [N-1:0] in_data;
    logic [N-1:0] add_a, add_b, add_result;
    logic add_refresh, add_overflow;
    logic out_valid, out_ready, out_sat;
    logic [N-1:0] out_data;

    always #5 clk = ~clk;

    accum_sequencer #(.N(N), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .add_a(add_a), .add_b(add_b), .add_refresh(add_refresh),
        .add_result(add_result), .add_overflow(add_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    // Registered adder model: latches a+b and signed overflow on refresh.
    logic [N-1:0] adder_sum;
    assign adder_sum = add_a + add_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            add_result   <= '0;
            add_overflow <= 1'b0;
        end else if (add_refresh) begin
            add_result   <= adder_sum;
            add_overflow <= (add_a[N-1] == add_b[N-1]) && (adder_sum[N-1] != add_a[N-1]);
        end
    end

    int checks = 0;
    int passes = 0;
    int valid_bursts = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (out_valid && !prev_valid) valid_bursts++;
        prev_valid = out_valid;
    end

    logic [N-1:0] ops[LEN];
    logic [N-1:0] exp_steps[LEN];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input string name, input logic [N-1:0] exp_out, input logic exp_sat,
                                 input int ready_delay, input bit gaps, input bit poke_start);
        int cyc = 0;
        int idx = 0;
        int nref = 0;
        int done_wait = 0;
        bit accept = 0;
        bit fin = 0;
        bit seen_valid = 0;
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (accept) idx++;
            if (add_refresh) begin
                if (nref < LEN) begin
                    checkOutput({name, " step_acc"}, add_a, exp_steps[nref]);
                    checkOutput({name, " step_opnd"}, add_b, ops[nref]);
                end
                nref++;
            end
            if (out_valid) begin
                if (!seen_valid && !gaps) checkOutput({name, " latency"}, cyc, 3 * LEN + 1);
                seen_valid = 1;
                checkOutput({name, " out_data"}, out_data, exp_out);
                checkOutput({name, " out_sat"}, out_sat, exp_sat);
                if (done_wait == ready_delay) begin
                    out_ready = 1'b1;
                    if (poke_start) start = 1'b1;
                    fin = 1;
                end
                done_wait++;
            end
            in_valid = (idx < LEN) && !(gaps && (cyc % 4 < 2));
            in_data = (idx < LEN) ? ops[idx] : '0;
            accept = in_ready && in_valid;
            if (poke_start && cyc == 5) start = 1'b1;
        end
        if (!fin) checkOutput({name, " timeout"}, 0, 1);
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        checkOutput({name, " idle_busy"}, busy, 0);
        checkOutput({name, " idle_valid"}, out_valid, 0);
        checkOutput({name, " refresh_count"}, nref, LEN);
        @(negedge clk);
        checkOutput({name, " stays_idle"}, busy, 0);
    endtask

    task automatic setVectors(input logic [N-1:0] o0, o1, o2, o3, input logic [N-1:0] s0, s1, s2, s3);
        ops[0] = o0; ops[1] = o1; ops[2] = o2; ops[3] = o3;
        exp_steps[0] = s0; exp_steps[1] = s1; exp_steps[2] = s2; exp_steps[3] = s3;
    endtask

    initial begin
        int nref;
        int guard;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst in_ready", in_ready, 0);
        checkOutput("rst refresh", add_refresh, 0);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst out_data", out_data, 0);
        checkOutput("rst add_a", add_a, 0);
        checkOutput("rst add_b", add_b, 0);
        checkOutput("rst out_sat", out_sat, 0);
        rst = 1'b0;

        setVectors(8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd10, 8'd30, 8'd60);
        applyStimulus("plain", 8'd100, 1'b0, 0, 0, 0);

        setVectors(8'd100, 8'd50, -8'sd10, 8'd5, 8'd0, 8'd100, 8'd127, 8'd117);
        applyStimulus("satpos", 8'd122, 1'b1, 0, 0, 0);

        setVectors(-8'sd100, -8'sd100, 8'd0, 8'd0, 8'd0, 8'h9C, 8'h80, 8'h80);
        applyStimulus("satneg", 8'h80, 1'b1, 0, 0, 0);

        setVectors(8'd127, 8'd1, -8'sd1, 8'd0, 8'd0, 8'd127, 8'd127, 8'd126);
        applyStimulus("leave_sat", 8'd126, 1'b1, 0, 0, 0);

        // Abort in the second CHECK cycle; nothing may be emitted.
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd1;
        nref = 0;
        guard = 0;
        while (nref < 2 && guard < 50) begin
            @(negedge clk);
            start = 1'b0;
            guard++;
            if (add_refresh) nref++;
        end
        checkOutput("abort reach", nref, 2);
        @(negedge clk);
        checkOutput("abort in_check", busy && !in_ready && !add_refresh, 1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort in_ready", in_ready, 0);
        checkOutput("abort refresh", add_refresh, 0);
        checkOutput("abort out_valid", out_valid, 0);
        checkOutput("abort out_data", out_data, 0);
        checkOutput("abort add_a", add_a, 0);
        checkOutput("abort add_b", add_b, 0);
        checkOutput("abort out_sat", out_sat, 0);

        setVectors(8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3);
        applyStimulus("after_abort", 8'd4, 1'b0, 0, 0, 0);

        setVectors(8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd3, 8'd6);
        applyStimulus("backpressure", 8'd10, 1'b0, 5, 1, 0);

        setVectors(8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd5, 8'd10, 8'd15);
        applyStimulus("start_poke", 8'd20, 1'b0, 2, 0, 1);

        repeat (3) @(negedge clk);
        checkOutput("final idle", busy, 0);
        checkOutput("valid bursts", valid_bursts, 7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
